serial_operand_sender: RTL and testbench
========================================

Name: serial_operand_sender

Overview:
- Transmitter end of the bit-serial add interface (vld/a/b/last out, sum back in).
- Accepts a pair of WIDTH-bit operands over a valid/ready handshake and emits them LSB-first, one bit pair per valid beat.
- Asserts last on the final beat and collects the returning serial sum bits into a parallel WIDTH-bit result.
- Sits between a parallel producer and a serial adder, so the adder can be driven and checked from word-level logic.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  one clock; reset is asynchronous and active-low.
- up_vld  input  1  operand pair valid.
- up_a  input  WIDTH  operand A.
- up_b  input  WIDTH  operand B.
- up_rdy  output  1  sender can accept an operand pair.
- stall  input  1  suppresses the serial beat this cycle (gap insertion).
- vld  output  1  serial beat valid.
- a  output  1  serial bit of A.
- b  output  1  serial bit of B.
- last  output  1  final bit of the word; only meaningful with vld.
- sum  input  1  serial sum bit from the adder, sampled combinationally in the same beat.
- res_vld  output  1  one-cycle pulse, res holds the completed sum.
- res  output  WIDTH  collected sum mod 2^WIDTH (carry-out dropped).

Behaviour:
- States are IDLE and SEND. The bit counter cnt is 0..WIDTH-1. The shift registers are sh_a and sh_b. The result shift register is acc.
- Reset (rst low, asynchronous):
  - state=IDLE, cnt=0, sh_a=sh_b=0, acc=0, res=0, res_vld=0.
  - Hence vld=0, last=0, a=b=0, up_rdy=1.
- up_rdy = (state==IDLE), combinational.
- IDLE:
  - On up_vld & up_rdy, load sh_a=up_a, sh_b=up_b, cnt=0, then go to SEND.
  - up_vld while not ready is ignored (the producer holds it).
- SEND:
  - a=sh_a[0], b=sh_b[0].
  - vld = !stall.
  - last = vld & (cnt==WIDTH-1).
  - While stall is high: vld=0, last=0, no shift, cnt holds, sum ignored.
- Each beat with vld=1:
  - Shift sh_a and sh_b right by one.
  - acc = {sum, acc[WIDTH-1:1]}, so sum from beat k lands at res bit k.
  - cnt++.
- Beat with last=1:
  - Next edge: res = final acc (including this sum bit), res_vld=1, state=IDLE, cnt=0.
- res_vld is high for exactly one cycle. res holds its value until the next completion or reset.
- Timing (no stall): handshake at edge T → beats at cycles T+1..T+WIDTH, last at T+WIDTH → res_vld in cycle T+WIDTH+1. up_rdy is high again in that same cycle.
- Minimum word period is WIDTH+1 cycles. Each stall cycle adds one.
- last never asserts without vld, so the adder's carry is cleared exactly once per word.
- Stall in IDLE has no effect.
- Reset mid-SEND:
  - Aborts the word: no res_vld, no last.
  - The downstream adder must share the same reset event so its carry is cleared.
- res_vld and a new handshake may coincide (IDLE entered with up_rdy=1); both proceed.

Test Plan:
- Bench loops the outputs into a serial adder model: sum=a^b^carry, carry cleared on vld&last or reset.
- WIDTH=8, A=0x5A, B=0x33, no stall → 8 vld beats, a bits 0,1,0,1,1,0,1,0, last only on beat 8, res_vld one cycle later with res=0x8D, up_rdy back high.
- A=0xFF, B=0x01 → res=0x00 (carry-out dropped). Next word A=0x01, B=0x01 → res=0x02, proving the carry was cleared by last.
- A=0x0F, B=0xF0 with stall high on beats 3 and 7 (two gaps) → vld low in those cycles, cnt and bits held, still exactly 8 valid beats, res_vld at T+11, res=0xFF.
- Back-to-back: up_vld held high with 3 queued pairs → each accepted the cycle res_vld of the previous word pulses, period 9 cycles, res values all correct.
- up_vld with new operands during SEND → not accepted (up_rdy=0), in-flight word unaffected.
- rst low after beat 4 of A=0xAA, B=0x55 → outputs zero immediately, no res_vld. After release, the word A=0x03, B=0x05 gives res=0x08.

Source files
------------

// File: rtl/serial_operand_sender.sv
// Bit-serial transmitter: takes a parallel operand pair, shifts it out LSB-first
// as (vld, a, b, last) beats and gathers the returning sum bits into a word.
module serial_operand_sender #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  output logic             up_rdy,
  input  logic             stall,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last,
  input  logic             sum,
  output logic             res_vld,
  output logic [WIDTH-1:0] res
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_vld_q, res_vld_d;

  logic             beat;
  logic             last_beat;
  logic [WIDTH-1:0] acc_shift;

  // A stalled cycle is a true gap: nothing shifts and the sum bit is not taken.
  assign beat      = (state_q == SEND) && !stall;
  assign last_beat = beat && (cnt_q == CNT_LAST);
  assign acc_shift = {sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    acc_d     = acc_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (up_vld) begin
          sh_a_d  = up_a;
          sh_b_d  = up_b;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat) begin
          sh_a_d = sh_a_q >> 1;
          sh_b_d = sh_b_q >> 1;
          acc_d  = acc_shift;
          cnt_d  = cnt_q + 1'b1;
          if (last_beat) begin
            res_d     = acc_shift;
            res_vld_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign up_rdy  = (state_q == IDLE);
  assign vld     = beat;
  assign last    = last_beat;
  assign a       = (state_q == SEND) && sh_a_q[0];
  assign b       = (state_q == SEND) && sh_b_q[0];
  assign res_vld = res_vld_q;
  assign res     = res_q;

endmodule

// File: tb/tb_serial_operand_sender.sv
// Directed bench: the sender drives a serial adder model whose sum bit loops
// back, and each word's beats and result are compared with hand-computed values.
module tb_serial_operand_sender;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             up_vld;
  logic [WIDTH-1:0] up_a;
  logic [WIDTH-1:0] up_b;
  logic             up_rdy;
  logic             stall;
  logic             vld;
  logic             a;
  logic             b;
  logic             last;
  logic             sum;
  logic             res_vld;
  logic [WIDTH-1:0] res;

  int n_vec = 0;
  int n_err = 0;

  serial_operand_sender #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .up_vld  (up_vld),
    .up_a    (up_a),
    .up_b    (up_b),
    .up_rdy  (up_rdy),
    .stall   (stall),
    .vld     (vld),
    .a       (a),
    .b       (b),
    .last    (last),
    .sum     (sum),
    .res_vld (res_vld),
    .res     (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial adder model: carry cleared by the last beat of a word or by reset.
  logic carry;
  assign sum = a ^ b ^ carry;
  always @(posedge clk or negedge rst) begin
    if (!rst)
      carry <= 1'b0;
    else if (vld)
      carry <= last ? 1'b0 : ((a & b) | (a & carry) | (b & carry));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Entered with up_vld/up_a/up_b already presented and the sender idle; the
  // handshake happens at the next rising edge. With 'more' set the producer
  // keeps up_vld high and presents the next pair, and the task returns in the
  // res_vld cycle so the next call's handshake lands on the following edge.
  task automatic run_word(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [15:0] smask, input logic [7:0] exp_res,
                          input bit more, input logic [7:0] na, input logic [7:0] nb);
    int beats;
    int cyc;
    check("rdy_before_hs", up_rdy, 1);
    @(posedge clk); #1;
    if (more) begin
      up_a = na;
      up_b = nb;
    end else begin
      up_vld = 1'b0;
    end
    beats = 0;
    cyc   = 0;
    while (beats < WIDTH && cyc < 30) begin
      stall = smask[cyc];
      @(negedge clk);
      check("vld", vld, !smask[cyc]);
      check("rdy_busy", up_rdy, 0);
      if (!smask[cyc]) begin
        check("a_bit", a, ta[beats]);
        check("b_bit", b, tb_v[beats]);
        check("last", last, (beats == WIDTH - 1));
        beats++;
      end else begin
        check("last_gap", last, 0);
      end
      check("res_vld_busy", res_vld, 0);
      cyc++;
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    check("res_vld", res_vld, 1);
    check("res", res, exp_res);
    check("rdy_done", up_rdy, 1);
    check("vld_done", vld, 0);
    $display("word a=%02h b=%02h stallmask=%04h -> res=%02h (exp %02h)",
             ta, tb_v, smask, res, exp_res);
    if (!more) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("res_vld_pulse", res_vld, 0);
      check("res_hold", res, exp_res);
    end
  endtask

  initial begin
    logic [7:0] va;
    va     = 8'hAA;
    rst    = 1'b0;
    up_vld = 1'b0;
    up_a   = '0;
    up_b   = '0;
    stall  = 1'b0;
    #1;
    check("rst_vld", vld, 0);
    check("rst_last", last, 0);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_rdy", up_rdy, 1);
    check("rst_res_vld", res_vld, 0);
    check("rst_res", res, 0);
    $display("reset state checked");

    @(negedge clk);
    rst = 1'b1;

    // Stall while idle does nothing.
    stall = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_stall_vld", vld, 0);
    check("idle_stall_rdy", up_rdy, 1);
    stall = 1'b0;

    up_vld = 1'b1; up_a = 8'h5A; up_b = 8'h33;
    run_word(8'h5A, 8'h33, 16'h0000, 8'h8D, 0, 8'h00, 8'h00);

    up_vld = 1'b1; up_a = 8'hFF; up_b = 8'h01;
    run_word(8'hFF, 8'h01, 16'h0000, 8'h00, 0, 8'h00, 8'h00);

    up_vld = 1'b1; up_a = 8'h01; up_b = 8'h01;
    run_word(8'h01, 8'h01, 16'h0000, 8'h02, 0, 8'h00, 8'h00);

    // Gaps in SEND cycles 3 and 7.
    up_vld = 1'b1; up_a = 8'h0F; up_b = 8'hF0;
    run_word(8'h0F, 8'hF0, 16'h0044, 8'hFF, 0, 8'h00, 8'h00);

    // Three queued pairs, up_vld held high throughout.
    up_vld = 1'b1; up_a = 8'h12; up_b = 8'h34;
    run_word(8'h12, 8'h34, 16'h0000, 8'h46, 1, 8'h80, 8'h80);
    run_word(8'h80, 8'h80, 16'h0000, 8'h00, 1, 8'hC8, 8'h64);
    run_word(8'hC8, 8'h64, 16'h0000, 8'h2C, 0, 8'h00, 8'h00);

    // Abort a word with reset after its fourth beat.
    up_vld = 1'b1; up_a = 8'hAA; up_b = 8'h55;
    @(posedge clk); #1;
    up_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_a_bit", a, va[i]);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("abort_vld", vld, 0);
    check("abort_last", last, 0);
    check("abort_a", a, 0);
    check("abort_b", b, 0);
    check("abort_rdy", up_rdy, 1);
    check("abort_res", res, 0);
    check("abort_res_vld", res_vld, 0);
    $display("reset mid-word applied");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_res_vld", res_vld, 0);
      check("post_abort_vld", vld, 0);
    end

    up_vld = 1'b1; up_a = 8'h03; up_b = 8'h05;
    run_word(8'h03, 8'h05, 16'h0000, 8'h08, 0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
